edge_impl_checker: RTL

//  Synthesisable, multi-channel checker for the property "a |-> ##[0:WINDOW] edge(b)".

---
 rtl/edge_impl_checker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/edge_impl_checker.sv
// ---------------------------------------------------------------------------
// edge_impl_checker
// Multi-channel on-chip monitor for the property "a |-> ##[0:WINDOW] edge(b)".
// Each channel runs an independent, non-overlapping attempt tracker. Results
// are reported as registered pass/fail pulses, saturating per-channel
// counters and a sticky error flag.
//
// Parameters
//   NCH     number of independent channels (>= 1)
//   WINDOW  samples after the trigger in which the edge may still occur
//           (0 = trigger sample only; no wait state is built)
//   CNT_W   width of each pass/fail counter (>= 2)
//
// Ports
//   clk         single clock, all sampling on posedge
//   rst         synchronous active-high reset
//   en          global enable; low blocks new attempts and aborts pending ones
//   mode        edge select: 00 fell, 01 rose, 10 any, 11 treated as fell
//   clr         synchronous clear of counters and err_sticky
//   a           per-channel trigger
//   b           per-channel monitored signal
//   pass_pulse  1-cycle pulse per channel on a passed attempt
//   fail_pulse  1-cycle pulse per channel on a failed attempt
//   pass_cnt    channel i at [i*CNT_W +: CNT_W], saturating
//   fail_cnt    channel i at [i*CNT_W +: CNT_W], saturating
//   err_sticky  set by any fail, cleared only by rst or clr
// ---------------------------------------------------------------------------
module edge_impl_checker #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned WINDOW = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 clr,
    input  logic [NCH-1:0]       a,
    input  logic [NCH-1:0]       b,
    output logic [NCH-1:0]       pass_pulse,
    output logic [NCH-1:0]       fail_pulse,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic                 err_sticky
);

    localparam logic [1:0]       MODE_FELL = 2'b00;
    localparam logic [1:0]       MODE_ROSE = 2'b01;
    localparam logic [1:0]       MODE_ANY  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    logic [NCH-1:0]            b_q;
    logic [NCH-1:0]            edge_c;
    logic [NCH-1:0]            pass_c;
    logic [NCH-1:0]            fail_c;
    logic [NCH-1:0]            pass_pulse_q;
    logic [NCH-1:0]            fail_pulse_q;
    logic [NCH-1:0][CNT_W-1:0] pass_cnt_q;
    logic [NCH-1:0][CNT_W-1:0] fail_cnt_q;
    logic                      err_sticky_q;

    // Previous-sample copy of b; tracked even while disabled so the first
    // enabled sample sees a genuine edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q <= '0;
        end else begin
            b_q <= b;
        end
    end

    // Edge detect for the selected mode; the reserved encoding behaves as fell.
    always_comb begin
        edge_c = b_q & ~b;
        case (mode)
            MODE_FELL: edge_c = b_q & ~b;
            MODE_ROSE: edge_c = ~b_q & b;
            MODE_ANY:  edge_c = b_q ^ b;
            default:   edge_c = b_q & ~b;
        endcase
    end

    // Per-channel attempt trackers.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        if (WINDOW == 0) begin : g_nowait
            // Single-sample window: the verdict is known at the trigger sample.
            assign pass_c[i] = en & a[i] & edge_c[i];
            assign fail_c[i] = en & a[i] & ~edge_c[i];
        end else begin : g_wait
            localparam int unsigned WCNT_W = $clog2(WINDOW + 1);

            state_e            state_q;
            state_e            state_d;
            logic [WCNT_W-1:0] wcnt_q;
            logic [WCNT_W-1:0] wcnt_d;
            logic              pass_l;
            logic              fail_l;
            logic              last_c;

            // wcnt counts samples elapsed since the trigger sample.
            assign last_c = (wcnt_q == WCNT_W'(WINDOW));

            // State register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    wcnt_q  <= '0;
                end else begin
                    state_q <= state_d;
                    wcnt_q  <= wcnt_d;
                end
            end

            // Next-state logic; triggers arriving during WAIT are ignored.
            always_comb begin
                state_d = state_q;
                wcnt_d  = wcnt_q;
                case (state_q)
                    ST_IDLE: begin
                        if (en && a[i] && !edge_c[i]) begin
                            state_d = ST_WAIT;
                            wcnt_d  = WCNT_W'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (!en || edge_c[i] || last_c) begin
                            state_d = ST_IDLE;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        wcnt_d  = '0;
                    end
                endcase
            end

            // Verdict decode; a disable during WAIT drops the attempt silently.
            always_comb begin
                pass_l = 1'b0;
                fail_l = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        pass_l = en & a[i] & edge_c[i];
                    end
                    ST_WAIT: begin
                        if (en) begin
                            if (edge_c[i]) begin
                                pass_l = 1'b1;
                            end else if (last_c) begin
                                fail_l = 1'b1;
                            end
                        end
                    end
                    default: begin
                        pass_l = 1'b0;
                        fail_l = 1'b0;
                    end
                endcase
            end

            assign pass_c[i] = pass_l;
            assign fail_c[i] = fail_l;
        end
    end

    // Registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_pulse_q <= '0;
            fail_pulse_q <= '0;
        end else begin
            pass_pulse_q <= pass_c;
            fail_pulse_q <= fail_c;
        end
    end

    // Saturating counters; clr takes priority over a same-cycle verdict.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (pass_c[ch] && (pass_cnt_q[ch] != CNT_MAX)) begin
                    pass_cnt_q[ch] <= pass_cnt_q[ch] + CNT_W'(1);
                end
                if (fail_c[ch] && (fail_cnt_q[ch] != CNT_MAX)) begin
                    fail_cnt_q[ch] <= fail_cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_sticky_q <= 1'b0;
        end else if (|fail_c) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign pass_pulse = pass_pulse_q;
    assign fail_pulse = fail_pulse_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule
